// File: rtl/placement_search.sv
// Placement search controller: sweeps every (x, rotation) candidate through an
// external scorer, copying the internal field RAM into the scorer, and keeps
// the lowest legal score.
// Build option: define PLACEMENT_SEARCH_RECOPY_EN to recopy the field before
// every candidate; otherwise the field is copied once per search.
module placement_search #(
  parameter int unsigned COLS     = 10,
  parameter int unsigned ROWS     = 25,
  parameter int unsigned AW       = 5,
  parameter int unsigned NX       = 10,
  parameter int unsigned XW       = 4,
  parameter int unsigned NROT     = 4,
  parameter int unsigned IW       = 2,
  parameter int unsigned SW       = 32,
  parameter int unsigned TIE_LAST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        fld_write_addr,
  input  logic [COLS-1:0]      fld_write_data,
  input  logic                 fld_write_enable,
  input  logic [NROT*16-1:0]   shape,
  input  logic                 start,
  input  logic                 abort,
  output logic [AW-1:0]        sc_write_addr,
  output logic [COLS-1:0]      sc_write_data,
  output logic                 sc_write_enable,
  output logic [XW-1:0]        sc_x,
  output logic [15:0]          sc_shape,
  output logic                 sc_start,
  input  logic                 sc_busy,
  input  logic [SW-1:0]        sc_score,
  input  logic                 sc_valid,
  output logic                 busy,
  output logic                 done,
  output logic [XW-1:0]        best_x,
  output logic [IW-1:0]        best_i,
  output logic [SW-1:0]        best_score,
  output logic                 best_found
);

`ifdef PLACEMENT_SEARCH_RECOPY_EN
  localparam bit RECOPY = 1'b1;
`else
  localparam bit RECOPY = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, COPY_INIT, COPY, LAUNCH, STARTED, WAIT, COMPARE, NEXT
  } state_t;

  state_t state, state_d;

  logic [COLS-1:0] mem [ROWS];
  logic [AW-1:0]   rd_addr, rd_addr_d;
  logic [IW-1:0]   cand_i, cand_i_d;
  logic [XW-1:0]   sc_x_d;
  logic [15:0]     sc_shape_d;
  logic [AW-1:0]   sc_write_addr_d;
  logic            sc_write_enable_d, sc_start_d;
  logic            busy_d, done_d;
  logic [XW-1:0]   best_x_d;
  logic [IW-1:0]   best_i_d;
  logic [SW-1:0]   best_score_d;
  logic            best_found_d;
  logic            last_cand, better;

  // Field RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (fld_write_enable && (32'(fld_write_addr) < ROWS)) begin
      mem[fld_write_addr] <= fld_write_data;
    end
  end

  // Field RAM read port, one-cycle latency, feeds the scorer copy data directly
  always_ff @(posedge clk) begin
    if (32'(rd_addr) < ROWS) begin
      sc_write_data <= mem[rd_addr];
    end else begin
      sc_write_data <= '0;
    end
  end

  assign last_cand = (sc_x == XW'(NX - 1)) && (cand_i == IW'(NROT - 1));
  assign better    = sc_valid && (!best_found || (sc_score < best_score) ||
                     ((TIE_LAST != 0) && (sc_score == best_score)));

  // Next-state and registered-output logic
  always_comb begin
    state_d           = state;
    rd_addr_d         = rd_addr;
    cand_i_d          = cand_i;
    sc_x_d            = sc_x;
    sc_shape_d        = sc_shape;
    sc_write_addr_d   = sc_write_addr;
    sc_write_enable_d = 1'b0;
    sc_start_d        = 1'b0;
    busy_d            = busy;
    done_d            = 1'b0;
    best_x_d          = best_x;
    best_i_d          = best_i;
    best_score_d      = best_score;
    best_found_d      = best_found;

    if ((state != IDLE) && abort) begin
      state_d      = IDLE;
      busy_d       = 1'b0;
      best_found_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            busy_d       = 1'b1;
            best_score_d = '1;
            best_found_d = 1'b0;
            sc_x_d       = '0;
            cand_i_d     = '0;
            sc_shape_d   = shape[15:0];
            state_d      = COPY_INIT;
          end
        end
        COPY_INIT: begin
          rd_addr_d = '0;
          state_d   = COPY;
        end
        COPY: begin
          // Row rd_addr is being read now; its write lands next cycle
          sc_write_enable_d = 1'b1;
          sc_write_addr_d   = rd_addr;
          if (32'(rd_addr) == ROWS - 1) begin
            state_d = LAUNCH;
          end else begin
            rd_addr_d = rd_addr + AW'(1);
          end
        end
        LAUNCH: begin
          sc_start_d = 1'b1;
          state_d    = STARTED;
        end
        STARTED: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (!sc_busy) begin
            state_d = COMPARE;
          end
        end
        COMPARE: begin
          if (better) begin
            best_x_d     = sc_x;
            best_i_d     = cand_i;
            best_score_d = sc_score;
            best_found_d = 1'b1;
          end
          state_d = NEXT;
        end
        NEXT: begin
          if (last_cand) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            if (cand_i == IW'(NROT - 1)) begin
              cand_i_d = '0;
              sc_x_d   = sc_x + XW'(1);
            end else begin
              cand_i_d = cand_i + IW'(1);
            end
            sc_shape_d = shape[32'(cand_i_d)*16 +: 16];
            state_d    = RECOPY ? COPY_INIT : LAUNCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rd_addr         <= '0;
      cand_i          <= '0;
      sc_x            <= '0;
      sc_shape        <= '0;
      sc_write_addr   <= '0;
      sc_write_enable <= 1'b0;
      sc_start        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      best_x          <= '0;
      best_i          <= '0;
      best_score      <= '1;
      best_found      <= 1'b0;
    end else begin
      state           <= state_d;
      rd_addr         <= rd_addr_d;
      cand_i          <= cand_i_d;
      sc_x            <= sc_x_d;
      sc_shape        <= sc_shape_d;
      sc_write_addr   <= sc_write_addr_d;
      sc_write_enable <= sc_write_enable_d;
      sc_start        <= sc_start_d;
      busy            <= busy_d;
      done            <= done_d;
      best_x          <= best_x_d;
      best_i          <= best_i_d;
      best_score      <= best_score_d;
      best_found      <= best_found_d;
    end
  end

endmodule

// File: tb/tb_placement_search.sv
// Directed bench for placement_search with a 3-cycle stub scorer.
// Two instances run in lockstep: TIE_LAST=1 (dut) and TIE_LAST=0 (dut0).
module tb_placement_search;
  localparam int unsigned COLS = 10, ROWS = 25, AW = 5, NX = 10, XW = 4;
  localparam int unsigned NROT = 4, IW = 2, SW = 32;
`ifdef PLACEMENT_SEARCH_RECOPY_EN
  localparam bit RECOPY = 1'b1;
`else
  localparam bit RECOPY = 1'b0;
`endif
  localparam int WR_PER_SEARCH = RECOPY ? ROWS * NX * NROT : ROWS;
  localparam int NCAND = NX * NROT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, fld_write_enable, start, abort;
  logic [AW-1:0] fld_write_addr;
  logic [COLS-1:0] fld_write_data;
  logic [NROT*16-1:0] shape;

  logic [AW-1:0] sc_write_addr, sc_write_addr0;
  logic [COLS-1:0] sc_write_data, sc_write_data0;
  logic sc_write_enable, sc_write_enable0, sc_start, sc_start0;
  logic [XW-1:0] sc_x, sc_x0, best_x, best_x0;
  logic [15:0] sc_shape, sc_shape0;
  logic busy, busy0, done, done0, best_found, best_found0;
  logic [IW-1:0] best_i, best_i0;
  logic [SW-1:0] best_score, best_score0;

  logic sc_busy, sc_valid;
  logic [SW-1:0] sc_score;

  placement_search #(.TIE_LAST(1)) dut (
    .clk(clk), .rst(rst),
    .fld_write_addr(fld_write_addr), .fld_write_data(fld_write_data),
    .fld_write_enable(fld_write_enable), .shape(shape), .start(start), .abort(abort),
    .sc_write_addr(sc_write_addr), .sc_write_data(sc_write_data),
    .sc_write_enable(sc_write_enable), .sc_x(sc_x), .sc_shape(sc_shape),
    .sc_start(sc_start), .sc_busy(sc_busy), .sc_score(sc_score), .sc_valid(sc_valid),
    .busy(busy), .done(done), .best_x(best_x), .best_i(best_i),
    .best_score(best_score), .best_found(best_found)
  );

  placement_search #(.TIE_LAST(0)) dut0 (
    .clk(clk), .rst(rst),
    .fld_write_addr(fld_write_addr), .fld_write_data(fld_write_data),
    .fld_write_enable(fld_write_enable), .shape(shape), .start(start), .abort(abort),
    .sc_write_addr(sc_write_addr0), .sc_write_data(sc_write_data0),
    .sc_write_enable(sc_write_enable0), .sc_x(sc_x0), .sc_shape(sc_shape0),
    .sc_start(sc_start0), .sc_busy(sc_busy), .sc_score(sc_score), .sc_valid(sc_valid),
    .busy(busy0), .done(done0), .best_x(best_x0), .best_i(best_i0),
    .best_score(best_score0), .best_found(best_found0)
  );

  // Stub scorer: busy 3 cycles per launch, score = 100-k or a flat 50
  logic [1:0] bcnt;
  int n_st, cur_k;
  logic flat_mode, valid_mode;
  assign sc_busy  = (bcnt != 2'd0);
  assign sc_score = flat_mode ? 32'd50 : 32'(100 - cur_k);
  assign sc_valid = valid_mode;

  always @(posedge clk) begin
    if (rst || start) begin
      bcnt <= 2'd0; n_st <= 0; cur_k <= 0;
    end else if (sc_start) begin
      bcnt <= 2'd3; cur_k <= n_st; n_st <= n_st + 1;
    end else if (bcnt != 2'd0) begin
      bcnt <= bcnt - 2'd1;
    end
  end

  // Scorer-side monitor: copy order, candidate order, start width, done pulses
  int mon_starts, wr_cnt, wr_bad, cand_bad, start_bad, done_cnt;
  logic [AW-1:0] exp_row;
  logic prev_start;

  function automatic logic [15:0] slice(input int i);
    logic [NROT*16-1:0] s;
    s = shape;
    return s[i*16 +: 16];
  endfunction

  always @(negedge clk) begin
    prev_start <= sc_start;
    if (rst || start) begin
      mon_starts <= 0; wr_cnt <= 0; wr_bad <= 0; cand_bad <= 0;
      start_bad <= 0; done_cnt <= 0; exp_row <= '0;
    end else begin
      if (sc_write_enable) begin
        wr_cnt <= wr_cnt + 1;
        if (sc_write_addr != exp_row || sc_write_data != COLS'(exp_row)) wr_bad <= wr_bad + 1;
        exp_row <= (32'(exp_row) == ROWS - 1) ? '0 : exp_row + AW'(1);
      end
      if (sc_start) begin
        mon_starts <= mon_starts + 1;
        if (sc_x != XW'(mon_starts / NROT) || sc_shape != slice(mon_starts % NROT))
          cand_bad <= cand_bad + 1;
        if (prev_start) start_bad <= start_bad + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_sc_start"}, 64'(sc_start), 64'd0);
    chk({tag, "_sc_we"}, 64'(sc_write_enable), 64'd0);
    chk({tag, "_best_x"}, 64'(best_x), 64'd0);
    chk({tag, "_best_i"}, 64'(best_i), 64'd0);
    chk({tag, "_best_score"}, 64'(best_score), 64'hFFFF_FFFF);
    chk({tag, "_best_found"}, 64'(best_found), 64'd0);
  endtask

  // Start a search, wait for done with a cycle budget, check the sweep itself
  task automatic run_search(input string tag);
    bit got;
    got = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4000 && !got; c++) begin
      tick();
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    tick();
    chk({tag, "_done_pulse"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_wr_cnt"}, 64'(wr_cnt), 64'(WR_PER_SEARCH));
    chk({tag, "_wr_order"}, 64'(wr_bad), 64'd0);
    chk({tag, "_cand_cnt"}, 64'(mon_starts), 64'(NCAND));
    chk({tag, "_cand_order"}, 64'(cand_bad), 64'd0);
    chk({tag, "_start_width"}, 64'(start_bad), 64'd0);
  endtask

  task automatic chk_best(input string tag, input logic [XW-1:0] x, input logic [IW-1:0] i,
                          input logic [SW-1:0] sc, input logic f,
                          input logic [XW-1:0] x0, input logic [IW-1:0] i0);
    chk({tag, "_best_x"}, 64'(best_x), 64'(x));
    chk({tag, "_best_i"}, 64'(best_i), 64'(i));
    chk({tag, "_best_score"}, 64'(best_score), 64'(sc));
    chk({tag, "_best_found"}, 64'(best_found), 64'(f));
    chk({tag, "_t0_best_x"}, 64'(best_x0), 64'(x0));
    chk({tag, "_t0_best_i"}, 64'(best_i0), 64'(i0));
    chk({tag, "_t0_best_score"}, 64'(best_score0), 64'(sc));
    chk({tag, "_t0_best_found"}, 64'(best_found0), 64'(f));
  endtask

  initial begin
    bit reached;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    fld_write_enable = 1'b0; fld_write_addr = '0; fld_write_data = '0;
    shape = 64'hF00F_0FF0_A5A5_1234;
    flat_mode = 1'b0; valid_mode = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset("reset");

    // Field row r holds value r
    for (int r = 0; r < int'(ROWS); r++) begin
      fld_write_enable = 1'b1;
      fld_write_addr = AW'(r);
      fld_write_data = COLS'(r);
      tick();
    end
    fld_write_enable = 1'b0;

    // Decreasing scores: last candidate wins on both tie policies
    run_search("desc");
    chk_best("desc", 4'd9, 2'd3, 32'd61, 1'b1, 4'd9, 2'd3);

    // Flat scores: tie policy decides
    flat_mode = 1'b1;
    run_search("flat");
    chk_best("flat", 4'd9, 2'd3, 32'd50, 1'b1, 4'd0, 2'd0);

    // Nothing legal: no result, position left as it was
    flat_mode = 1'b0; valid_mode = 1'b0;
    run_search("none");
    chk_best("none", 4'd9, 2'd3, 32'hFFFF_FFFF, 1'b0, 4'd0, 2'd0);

    // Abort during the third candidate's wait
    valid_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 2000 && !reached; c++) begin
      tick();
      if (mon_starts == 3 && sc_busy) reached = 1'b1;
    end
    chk("abort_reached", 64'(reached), 64'd1);
    chk("abort_pre_found", 64'(best_found), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_found", 64'(best_found), 64'd0);
    chk("abort_sc_start", 64'(sc_start), 64'd0);
    chk("abort_sc_we", 64'(sc_write_enable), 64'd0);
    repeat (60) tick();
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_idle_busy", 64'(busy), 64'd0);

    run_search("after_abort");
    chk_best("after_abort", 4'd9, 2'd3, 32'd61, 1'b1, 4'd9, 2'd3);

    // Abort in idle is a no-op; start with abort does not launch
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_found", 64'(best_found), 64'd1);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    chk("start_abort_busy", 64'(busy), 64'd0);
    chk("start_abort_found", 64'(best_found), 64'd1);

    // Reset in the middle of the field copy
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("midcopy_we", 64'(sc_write_enable), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("midcopy_rst");
    repeat (3) tick();
    chk("midcopy_quiet_we", 64'(sc_write_enable), 64'd0);

    // Field RAM kept its contents across reset
    run_search("post_rst");
    chk_best("post_rst", 4'd9, 2'd3, 32'd61, 1'b1, 4'd9, 2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
